// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the signed-byte 7-segment display.
// Build option: SEG7_HEX_DISPLAY_EN shows the byte as raw hex instead.
package seg7_pkg;

  localparam int REFRESH_DIV_DEF = 31250;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_LOAD    = 2'd2
  } state_t;

  typedef struct packed {
    logic       neg;
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
  } disp_t;

  localparam logic [6:0] G_0     = 7'b1000000;
  localparam logic [6:0] G_1     = 7'b1111001;
  localparam logic [6:0] G_2     = 7'b0100100;
  localparam logic [6:0] G_3     = 7'b0110000;
  localparam logic [6:0] G_4     = 7'b0011001;
  localparam logic [6:0] G_5     = 7'b0010010;
  localparam logic [6:0] G_6     = 7'b0000010;
  localparam logic [6:0] G_7     = 7'b1111000;
  localparam logic [6:0] G_8     = 7'b0000000;
  localparam logic [6:0] G_9     = 7'b0010000;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_B     = 7'b0000011;
  localparam logic [6:0] G_C     = 7'b1000110;
  localparam logic [6:0] G_D     = 7'b0100001;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_F     = 7'b0001110;
  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  function automatic logic [6:0] dec_glyph(
    input logic [3:0] d
  );
    logic [6:0] g;
    g = G_BLANK;
    unique case (d)
      4'd0: g = G_0;
      4'd1: g = G_1;
      4'd2: g = G_2;
      4'd3: g = G_3;
      4'd4: g = G_4;
      4'd5: g = G_5;
      4'd6: g = G_6;
      4'd7: g = G_7;
      4'd8: g = G_8;
      4'd9: g = G_9;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] hex_glyph(
    input logic [3:0] d
  );
    logic [6:0] g;
    g = dec_glyph(d);
    unique case (d)
      4'hA: g = G_A;
      4'hB: g = G_B;
      4'hC: g = G_C;
      4'hD: g = G_D;
      4'hE: g = G_E;
      4'hF: g = G_F;
      default: g = dec_glyph(d);
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_8.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits.
// One shift per cycle; done pulses after the 8th shift.
module bin2bcd_8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [19:0] sh_q, sh_d, adj;
  logic [2:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Shift register state; results hold once the run ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  // Add-3 correction on each BCD nibble, then shift left.
  always_comb begin
    adj          = sh_q;
    adj[11:8]    = add3(sh_q[11:8]);
    adj[15:12]   = add3(sh_q[15:12]);
    adj[19:16]   = add3(sh_q[19:16]);
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    run_d        = run_q;
    done_d       = 1'b0;
    if (start) begin
      sh_d  = {12'd0, bin};
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = {adj[18:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign done = done_q;
  assign bcd  = sh_q[19:8];

endmodule

// File: rtl/seg7_data_display.sv
// Shows a signed sample byte on a 4-digit multiplexed 7-seg display.
// Build option: SEG7_HEX_DISPLAY_EN selects raw hex on the right two digits.
module seg7_data_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       DP,
  output logic       BUSY,
  output logic       OVERRUN
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

  state_t        state_q, state_d;
  logic [7:0]    sample_q, sample_d;
  disp_t         disp_q, disp_d;
  logic          ovr_q, ovr_d;
  logic [CW-1:0] ref_q, ref_d;
  logic [1:0]    idx_q, idx_d;
  logic          start;

`ifndef SEG7_HEX_DISPLAY_EN
  logic [7:0]  mag;
  logic        bcd_done;
  logic [11:0] bcd;

  assign mag = DATA_IN[7] ? 8'(-DATA_IN) : DATA_IN;

  bin2bcd_8 u_bcd (
    .clk   (CLK),
    .rst   (RST),
    .start (start),
    .bin   (mag),
    .done  (bcd_done),
    .bcd   (bcd)
  );
`endif

  // Control, sample and display registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sample_q <= '0;
      disp_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      disp_q   <= disp_d;
      ovr_q    <= ovr_d;
    end
  end

  // FSM: accept in IDLE, drop and flag anything arriving while busy.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    disp_d   = disp_q;
    ovr_d    = ovr_q;
    start    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (DATA_VALID) begin
          sample_d = DATA_IN;
          ovr_d    = 1'b0;
          start    = 1'b1;
`ifdef SEG7_HEX_DISPLAY_EN
          state_d  = S_LOAD;
`else
          state_d  = S_CONVERT;
`endif
        end
      end
      S_CONVERT: begin
        if (DATA_VALID) ovr_d = 1'b1;
`ifdef SEG7_HEX_DISPLAY_EN
        state_d = S_IDLE;
`else
        if (bcd_done) state_d = S_LOAD;
`endif
      end
      S_LOAD: begin
        if (DATA_VALID) ovr_d = 1'b1;
`ifdef SEG7_HEX_DISPLAY_EN
        disp_d.neg = 1'b0;
        disp_d.hun = 4'd0;
        disp_d.ten = sample_q[7:4];
        disp_d.one = sample_q[3:0];
`else
        disp_d.neg = sample_q[7];
        disp_d.hun = bcd[11:8];
        disp_d.ten = bcd[7:4];
        disp_d.one = bcd[3:0];
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Free-running digit scan, untouched by display updates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ref_q <= '0;
      idx_q <= '0;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
    end
  end

  // Refresh counter wrap advances the digit index.
  always_comb begin
    ref_d = ref_q + CW'(1);
    idx_d = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Segment pattern for the currently enabled digit.
  always_comb begin
    SEG = G_BLANK;
    unique case (idx_q)
`ifdef SEG7_HEX_DISPLAY_EN
      2'd0: SEG = hex_glyph(disp_q.one);
      2'd1: SEG = hex_glyph(disp_q.ten);
      2'd2: SEG = G_BLANK;
      2'd3: SEG = G_BLANK;
`else
      2'd0: SEG = dec_glyph(disp_q.one);
      2'd1: SEG = (disp_q.hun == 4'd0 && disp_q.ten == 4'd0)
                  ? G_BLANK : dec_glyph(disp_q.ten);
      2'd2: SEG = (disp_q.hun == 4'd0)
                  ? G_BLANK : dec_glyph(disp_q.hun);
      2'd3: SEG = disp_q.neg ? G_DASH : G_BLANK;
`endif
      default: SEG = G_BLANK;
    endcase
  end

  assign AN      = ~(4'b0001 << idx_q);
  assign DP      = 1'b1;
  assign BUSY    = (state_q != S_IDLE);
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_seg7_data_display.sv
// Directed self-checking bench for seg7_data_display (decimal build).
module tb_seg7_data_display;

  localparam int DIV = 4;

  localparam logic [6:0] E0 = 7'b1000000;
  localparam logic [6:0] E1 = 7'b1111001;
  localparam logic [6:0] E2 = 7'b0100100;
  localparam logic [6:0] E5 = 7'b0010010;
  localparam logic [6:0] E6 = 7'b0000010;
  localparam logic [6:0] E7 = 7'b1111000;
  localparam logic [6:0] E8 = 7'b0000000;
  localparam logic [6:0] EM = 7'b0111111;
  localparam logic [6:0] EB = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       dv  = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp, busy, ovr;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_g [4];

  seg7_data_display #(.REFRESH_DIV(DIV)) dut (
    .CLK        (clk),
    .RST        (rst),
    .DATA_IN    (din),
    .DATA_VALID (dv),
    .SEG        (seg),
    .AN         (an),
    .DP         (dp),
    .BUSY       (busy),
    .OVERRUN    (ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    dv  = 1'b1;
    din = b;
    @(negedge clk);
    dv  = 1'b0;
  endtask

  task automatic set_exp(
    input logic [6:0] d3, d2, d1, d0
  );
    exp_g[3] = d3;
    exp_g[2] = d2;
    exp_g[1] = d1;
    exp_g[0] = d0;
  endtask

  task automatic chk_lit(input string tag);
    int k;
    k = -1;
    case (an)
      4'b1110: k = 0;
      4'b1101: k = 1;
      4'b1011: k = 2;
      4'b0111: k = 3;
      default: k = -1;
    endcase
    if (k < 0) chk({tag, "_an"}, an, 4'b1110);
    else chk(tag, seg, exp_g[k]);
  endtask

  task automatic show(input string tag);
    logic [3:0] want;
    int n;
    for (int k = 0; k < 4; k++) begin
      want = ~(4'b0001 << k);
      n = 0;
      while (an !== want && n < 5 * DIV) begin
        @(negedge clk);
        n++;
      end
      if (an !== want) chk({tag, "_to"}, an, want);
      else chk($sformatf("%s_d%0d", tag, k), seg, exp_g[k]);
    end
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_dp", dp, 1'b1);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, E0);
    for (int k = 0; k < 4 * DIV; k++) begin
      logic [3:0] wa;
      logic [6:0] ws;
      wa = ~(4'b0001 << ((k / DIV) % 4));
      ws = ((k / DIV) == 0) ? E0 : EB;
      chk($sformatf("scan_an%0d", k), an, wa);
      chk($sformatf("scan_seg%0d", k), seg, ws);
      @(negedge clk);
    end

    set_exp(EB, EB, EB, E0);
    pulse(8'h7F);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("busy_c%0d", i), busy, 1'b1);
      if (i == 9) chk_lit("lat_old");
      @(negedge clk);
    end
    chk("busy_end", busy, 1'b0);
    set_exp(EB, E1, E2, E7);
    chk_lit("lat_new");
    chk("ovr_7f", ovr, 1'b0);
    show("v127");

    send(8'h80);
    set_exp(EM, E1, E2, E8);
    show("vm128");

    send(8'hF6);
    set_exp(EM, EB, E1, E0);
    show("vm10");

    pulse(8'h05);
    repeat (9) @(negedge clk);
    dv  = 1'b1;
    din = 8'h33;
    @(negedge clk);
    dv  = 1'b0;
    chk("load_drop_ovr", ovr, 1'b1);
    chk("load_drop_busy", busy, 1'b0);
    repeat (12) @(negedge clk);
    set_exp(EB, EB, EB, E5);
    show("v5");

    pulse(8'h10);
    chk("acc_clr_ovr", ovr, 1'b0);
    repeat (2) @(negedge clk);
    dv  = 1'b1;
    din = 8'h20;
    @(negedge clk);
    dv  = 1'b0;
    chk("busy_drop_ovr", ovr, 1'b1);
    repeat (12) @(negedge clk);
    set_exp(EB, EB, E1, E6);
    show("v16");
    chk("ovr_sticky", ovr, 1'b1);

    send(8'h01);
    chk("ovr_clr", ovr, 1'b0);
    set_exp(EB, EB, EB, E1);
    show("v1");

    pulse(8'h7F);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_an", an, 4'b1110);
    chk("abort_seg", seg, E0);
    repeat (12) @(negedge clk);
    set_exp(EB, EB, EB, E0);
    show("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
